// File: rtl/hv_sram_arbiter.sv
// Arbitrates the three HV SRAM banks between the host load port and the run-time read port,
// gating reads until the initial load finishes and tracking reads through the 2-cycle SRAM.
module hv_sram_arbiter #(
    parameter int unsigned HV_WIDTH     = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [4:0]          ld_addr,
    input  logic [HV_WIDTH-1:0] ld_data,
    input  logic                ld_last,
    output logic                init_done,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [4:0]          rd_addr,
    output logic [HV_WIDTH-1:0] rd_data,
    output logic                rd_data_valid,
    output logic [2:0]          addr_1,
    output logic [2:0]          addr_2,
    output logic [2:0]          addr_3,
    output logic                we_1,
    output logic                we_2,
    output logic                we_3,
    output logic [HV_WIDTH-1:0] wdata_1,
    output logic [HV_WIDTH-1:0] wdata_2,
    output logic [HV_WIDTH-1:0] wdata_3,
    input  logic [HV_WIDTH-1:0] hv_1,
    input  logic [HV_WIDTH-1:0] hv_2,
    input  logic [HV_WIDTH-1:0] hv_3
);
    localparam int unsigned NBANK = 3;
    localparam int unsigned BW    = 2;
    localparam int unsigned RW    = 3;
    localparam int unsigned CW    = 3;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t              r_state;
    logic                r_init_done;
    logic [CW-1:0]       r_stall_cnt;
    logic                r_p1_v;
    logic                r_p2_v;
    logic [BW-1:0]       r_p1_bank;
    logic [BW-1:0]       r_p2_bank;

    logic [BW-1:0]       w_ld_bank;
    logic [BW-1:0]       w_rd_bank;
    logic                w_conflict;
    logic                w_starved;
    logic                w_ld_grant;
    logic                w_rd_grant;
    logic [RW-1:0]       w_addr  [NBANK];
    logic                w_we    [NBANK];
    logic [HV_WIDTH-1:0] w_wdata [NBANK];

    // 00 -> bank 1, 01 -> bank 2, 1x -> bank 3 (encoded 0/1/2)
    function automatic logic [BW-1:0] bank_of(input logic [4:0] a);
        return a[4] ? BW'(2) : BW'(a[3]);
    endfunction

    assign w_ld_bank  = bank_of(ld_addr);
    assign w_rd_bank  = bank_of(rd_addr);
    assign w_conflict = ld_valid && rd_valid && (w_ld_bank == w_rd_bank);
    assign w_starved  = (r_stall_cnt >= CW'(STARVE_LIMIT));

    always_comb begin
        ld_ready = 1'b0;
        rd_ready = 1'b0;
        if (!rst) begin
            if (r_state == S_LOAD) begin
                ld_ready = 1'b1;
            end else begin
                ld_ready = !(w_conflict && !w_starved);
                rd_ready = !(w_conflict && w_starved);
            end
        end
    end

    assign w_ld_grant = ld_valid && ld_ready;
    assign w_rd_grant = rd_valid && rd_ready;

    // Per-bank drive; arbitration guarantees load and read never share a bank here
    always_comb begin
        for (int b = 0; b < int'(NBANK); b++) begin
            w_addr[b]  = '0;
            w_we[b]    = 1'b0;
            w_wdata[b] = '0;
            if (w_ld_grant && (w_ld_bank == BW'(b))) begin
                w_addr[b]  = ld_addr[RW-1:0];
                w_we[b]    = 1'b1;
                w_wdata[b] = ld_data;
            end else if (w_rd_grant && (w_rd_bank == BW'(b))) begin
                w_addr[b] = rd_addr[RW-1:0];
            end
        end
    end

    assign addr_1  = w_addr[0];
    assign addr_2  = w_addr[1];
    assign addr_3  = w_addr[2];
    assign we_1    = w_we[0];
    assign we_2    = w_we[1];
    assign we_3    = w_we[2];
    assign wdata_1 = w_wdata[0];
    assign wdata_2 = w_wdata[1];
    assign wdata_3 = w_wdata[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_init_done <= 1'b0;
            r_stall_cnt <= '0;
            r_p1_v      <= 1'b0;
            r_p2_v      <= 1'b0;
            r_p1_bank   <= '0;
            r_p2_bank   <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (ld_valid && ld_last) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase

            // Saturating count of loads lost to a same-bank read
            if (w_ld_grant) begin
                r_stall_cnt <= '0;
            end else if (ld_valid && w_conflict && (r_state == S_RUN) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end

            r_p1_v    <= w_rd_grant;
            r_p1_bank <= w_rd_bank;
            r_p2_v    <= r_p1_v;
            r_p2_bank <= r_p1_bank;
        end
    end

    assign init_done     = r_init_done;
    assign rd_data_valid = r_p2_v;

    always_comb begin
        rd_data = '0;
        if (r_p2_v) begin
            case (r_p2_bank)
                BW'(0):  rd_data = hv_1;
                BW'(1):  rd_data = hv_2;
                default: rd_data = hv_3;
            endcase
        end
    end
endmodule

// File: tb/tb_hv_sram_arbiter.sv
// Randomized bench for hv_sram_arbiter: a behavioural SRAM plus a rule-level reference model
// (flat memory image, expected-read queue, starvation counter) checked every cycle.
module tb_hv_sram_arbiter;
    localparam int unsigned W      = 64;
    localparam int unsigned STARVE = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_valid, ld_ready, ld_last, init_done;
    logic [4:0]   ld_addr;
    logic [W-1:0] ld_data;
    logic         rd_valid, rd_ready, rd_data_valid;
    logic [4:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic [2:0]   addr_1, addr_2, addr_3;
    logic         we_1, we_2, we_3;
    logic [W-1:0] wdata_1, wdata_2, wdata_3;
    logic [W-1:0] hv_1, hv_2, hv_3;

    hv_sram_arbiter #(.HV_WIDTH(W), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_last(ld_last), .init_done(init_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
        .we_1(we_1), .we_2(we_2), .we_3(we_3),
        .wdata_1(wdata_1), .wdata_2(wdata_2), .wdata_3(wdata_3),
        .hv_1(hv_1), .hv_2(hv_2), .hv_3(hv_3)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM banks: read-first, data appears 2 cycles after the address
    logic [2:0]   a_o [3];
    logic         we_o[3];
    logic [W-1:0] wd_o[3];
    logic [W-1:0] sram[3][8];
    logic [W-1:0] s1[3], s2[3];
    assign a_o[0] = addr_1;  assign a_o[1] = addr_2;  assign a_o[2] = addr_3;
    assign we_o[0] = we_1;   assign we_o[1] = we_2;   assign we_o[2] = we_3;
    assign wd_o[0] = wdata_1; assign wd_o[1] = wdata_2; assign wd_o[2] = wdata_3;
    assign hv_1 = s2[0];  assign hv_2 = s2[1];  assign hv_3 = s2[2];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (we_o[b]) sram[b][a_o[b]] <= wd_o[b];
            s1[b] <= sram[b][a_o[b]];
            s2[b] <= s1[b];
        end
    end

    // Reference model state
    typedef struct { int due; logic [W-1:0] d; } rexp_t;
    rexp_t        exp_q[$];
    logic [W-1:0] ref_mem[3][8];
    bit           m_run, m_init;
    int           m_stall, cyc;
    int           n_vec, n_bad;
    bit           obs_ld_rdy;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int bank_of(input logic [4:0] a);
        int hi;
        hi = int'(a) / 8;
        return (hi >= 2) ? 2 : hi;
    endfunction

    // One clock cycle: check everything at negedge, then advance the model on posedge
    task automatic step();
        int lb, rb;
        bit conf, eld, erd, lg, rg, exp_v;
        logic [W-1:0] exp_d;
        logic [2:0]   ea;
        @(negedge clk);
        lb = bank_of(ld_addr);
        rb = bank_of(rd_addr);
        conf = ld_valid && rd_valid && (lb == rb);
        if (rst)        begin eld = 0; erd = 0; end
        else if (!m_run) begin eld = 1; erd = 0; end
        else if (conf)  begin eld = (m_stall >= STARVE); erd = !eld; end
        else            begin eld = 1; erd = 1; end
        lg = ld_valid && eld;
        rg = rd_valid && erd;

        check_eq("ld_ready", W'(ld_ready), W'(eld));
        check_eq("rd_ready", W'(rd_ready), W'(erd));
        check_eq("init_done", W'(init_done), W'(m_init));

        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_d = exp_v ? exp_q[0].d : '0;
        if (exp_v) void'(exp_q.pop_front());
        check_eq("rd_data_valid", W'(rd_data_valid), W'(exp_v));
        check_eq("rd_data", rd_data, exp_d);

        for (int b = 0; b < 3; b++) begin
            ea = '0;
            if (lg && lb == b)      ea = ld_addr[2:0];
            else if (rg && rb == b) ea = rd_addr[2:0];
            check_eq($sformatf("we_%0d", b + 1), W'(we_o[b]), W'(lg && lb == b));
            check_eq($sformatf("addr_%0d", b + 1), W'(a_o[b]), W'(ea));
            if (!(rg && rb == b))
                check_eq($sformatf("wdata_%0d", b + 1), wd_o[b], (lg && lb == b) ? ld_data : '0);
        end
        obs_ld_rdy = ld_ready;

        @(posedge clk);
        if (rst) begin
            m_run = 0; m_init = 0; m_stall = 0;
            exp_q.delete();
        end else begin
            if (rg) exp_q.push_back('{due: cyc + 2, d: ref_mem[rb][rd_addr[2:0]]});
            if (lg) ref_mem[lb][ld_addr[2:0]] = ld_data;
            if (lg) m_stall = 0;
            else if (ld_valid && m_run && conf && m_stall < 7) m_stall++;
            if (!m_run && ld_valid && ld_last) begin m_run = 1; m_init = 1; end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        ld_valid = 0; rd_valid = 0; ld_last = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_all();
        for (int a = 0; a < 24; a++) begin
            ld_valid = 1; ld_addr = 5'(a); ld_data = {$urandom, $urandom};
            ld_last  = (a == 23);
            rd_valid = 1'($urandom % 2); rd_addr = 5'($urandom);
            step();
        end
        idle(1);
    endtask

    task automatic starve_round();
        int n;
        rd_valid = 1; rd_addr = 5'h03;
        ld_valid = 1; ld_addr = 5'h05; ld_data = {$urandom, $urandom}; ld_last = 0;
        n = 0;
        do begin step(); n++; end while (!obs_ld_rdy && n < 10);
        check_eq("starve_wait", W'(n), W'(STARVE + 1));
        idle(3);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        m_run = 0; m_init = 0; m_stall = 0;
        for (int b = 0; b < 3; b++) for (int r = 0; r < 8; r++) ref_mem[b][r] = '0;
        for (int b = 0; b < 3; b++) for (int r = 0; r < 8; r++) sram[b][r] = '0;
        rst = 1; ld_valid = 0; rd_valid = 0; ld_last = 0;
        ld_addr = '0; rd_addr = '0; ld_data = '0;
        @(posedge clk); #1;
        step(); step();
        rst = 0;
        idle(2);

        load_all();

        // back-to-back reads across banks 2 and 3
        rd_valid = 1; rd_addr = 5'h09; step();
        rd_addr = 5'h12; step();
        idle(4);

        // load and read on different banks in one cycle
        ld_valid = 1; ld_addr = 5'h01; ld_data = {$urandom, $urandom};
        rd_valid = 1; rd_addr = 5'h0A; step();
        idle(3);

        starve_round();
        starve_round();

        // read-after-write to the same row
        ld_valid = 1; ld_addr = 5'h11; ld_data = 64'hA5A5_5A5A_DEAD_BEEF; step();
        ld_valid = 0; rd_valid = 1; rd_addr = 5'h11; step();
        idle(4);

        // reset squashes an in-flight read
        rd_valid = 1; rd_addr = 5'h04; step();
        rd_valid = 0; rst = 1; step();
        rst = 0;
        idle(5);

        load_all();

        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom % 200) == 0;
            ld_valid = 1'($urandom % 2);
            rd_valid = 1'($urandom % 4 != 0);
            ld_addr  = 5'($urandom);
            rd_addr  = ($urandom % 3 == 0) ? ld_addr : 5'($urandom);
            ld_data  = {$urandom, $urandom};
            ld_last  = ($urandom % 16) == 0;
            step();
        end
        rst = 0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
